// File: rtl/video_sync_monitor.sv
// Video sync monitor: rebuilds pixel/line position from the hreset/vreset pulse
// trains, measures line and frame length, and tracks lock against the nominal raster.
module video_sync_monitor #(
   parameter int unsigned HW          = 10,
   parameter int unsigned VW          = 9,
   parameter int unsigned H_TOTAL     = 455,
   parameter int unsigned V_TOTAL     = 262,
   parameter int unsigned LOCK_FRAMES = 2
) (
   input  logic          clk,
   input  logic          _reset,
   input  logic          hreset_in,
   input  logic          vreset_in,
   output logic [HW-1:0] hpos,
   output logic [VW-1:0] vpos,
   output logic [HW-1:0] h_len,
   output logic [VW-1:0] v_len,
   output logic          locked,
   output logic          frame_start,
   output logic          lock_lost,
   output logic [7:0]    bad_frames
);
   typedef enum logic [1:0] {StAcquire, StMeasure, StLocked} state_e;

   localparam logic [HW-1:0] HTot  = HW'(H_TOTAL);
   localparam logic [VW-1:0] VTot  = VW'(V_TOTAL);
   localparam logic [3:0]    LockN = 4'(LOCK_FRAMES);

   state_e        state_q, state_d;
   logic          hreset_q, vreset_q;
   logic [HW-1:0] hpos_q, hpos_d, h_len_q, h_len_d;
   logic [VW-1:0] vpos_q, vpos_d, v_len_q, v_len_d;
   logic          h_armed_q, h_armed_d;
   logic          frame_bad_q, frame_bad_d;
   logic [3:0]    good_cnt_q, good_cnt_d;
   logic          locked_q, locked_d;
   logic          frame_start_q, frame_start_d;
   logic          lock_lost_q, lock_lost_d;
   logic [7:0]    bad_frames_q, bad_frames_d;

   logic          hr_edge, vr_edge, line_bad, frame_good, timeout, count_bad;
   logic [HW-1:0] hpos_inc;
   logic [VW-1:0] vpos_inc;

   always_comb begin
      hr_edge    = hreset_in & ~hreset_q;
      vr_edge    = vreset_in & ~vreset_q;
      hpos_inc   = hpos_q + 1'b1;
      vpos_inc   = vpos_q + 1'b1;
      // An edge landing on a saturated counter resynchronises it instead of timing out.
      timeout    = ((&hpos_q) & ~hr_edge) | ((&vpos_q) & ~vr_edge);
      line_bad   = hr_edge & h_armed_q & (hpos_inc != HTot);
      frame_good = (vpos_inc == VTot) & ~frame_bad_q & ~line_bad;
   end

   always_comb begin
      hpos_d        = hpos_q;
      h_len_d       = h_len_q;
      h_armed_d     = h_armed_q;
      vpos_d        = vpos_q;
      v_len_d       = v_len_q;
      frame_bad_d   = frame_bad_q;
      frame_start_d = vr_edge;

      if (hr_edge) begin
         h_len_d   = hpos_inc;
         hpos_d    = '0;
         h_armed_d = 1'b1;
      end else if (!(&hpos_q)) begin
         hpos_d = hpos_inc;
      end
      if (timeout) begin
         h_armed_d = 1'b0;
      end

      if (vr_edge) begin
         v_len_d     = vpos_inc;
         vpos_d      = '0;
         frame_bad_d = 1'b0;
      end else begin
         if (hr_edge && !(&vpos_q)) begin
            vpos_d = vpos_inc;
         end
         if (line_bad) begin
            frame_bad_d = 1'b1;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      good_cnt_d  = good_cnt_q;
      locked_d    = locked_q;
      lock_lost_d = 1'b0;
      count_bad   = 1'b0;

      if (timeout) begin
         state_d     = StAcquire;
         good_cnt_d  = '0;
         locked_d    = 1'b0;
         lock_lost_d = (state_q == StLocked);
      end else begin
         unique case (state_q)
            StAcquire: begin
               // The partial frame seen after acquisition is never judged.
               if (vr_edge) begin
                  state_d    = StMeasure;
                  good_cnt_d = '0;
               end
            end
            StMeasure: begin
               if (vr_edge) begin
                  if (frame_good) begin
                     if (good_cnt_q + 4'd1 == LockN) begin
                        state_d    = StLocked;
                        locked_d   = 1'b1;
                        good_cnt_d = '0;
                     end else begin
                        good_cnt_d = good_cnt_q + 4'd1;
                     end
                  end else begin
                     good_cnt_d = '0;
                     count_bad  = 1'b1;
                  end
               end
            end
            StLocked: begin
               if (line_bad || (vr_edge && !frame_good)) begin
                  state_d     = StMeasure;
                  locked_d    = 1'b0;
                  good_cnt_d  = '0;
                  lock_lost_d = 1'b1;
                  count_bad   = vr_edge;
               end
            end
            default: state_d = StAcquire;
         endcase
      end

      bad_frames_d = bad_frames_q;
      if (count_bad && !(&bad_frames_q)) begin
         bad_frames_d = bad_frames_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge _reset) begin
      if (!_reset) begin
         state_q       <= StAcquire;
         hreset_q      <= 1'b0;
         vreset_q      <= 1'b0;
         hpos_q        <= '0;
         h_len_q       <= '0;
         vpos_q        <= '0;
         v_len_q       <= '0;
         h_armed_q     <= 1'b0;
         frame_bad_q   <= 1'b0;
         good_cnt_q    <= '0;
         locked_q      <= 1'b0;
         frame_start_q <= 1'b0;
         lock_lost_q   <= 1'b0;
         bad_frames_q  <= '0;
      end else begin
         state_q       <= state_d;
         hreset_q      <= hreset_in;
         vreset_q      <= vreset_in;
         hpos_q        <= hpos_d;
         h_len_q       <= h_len_d;
         vpos_q        <= vpos_d;
         v_len_q       <= v_len_d;
         h_armed_q     <= h_armed_d;
         frame_bad_q   <= frame_bad_d;
         good_cnt_q    <= good_cnt_d;
         locked_q      <= locked_d;
         frame_start_q <= frame_start_d;
         lock_lost_q   <= lock_lost_d;
         bad_frames_q  <= bad_frames_d;
      end
   end

   assign hpos        = hpos_q;
   assign vpos        = vpos_q;
   assign h_len       = h_len_q;
   assign v_len       = v_len_q;
   assign locked      = locked_q;
   assign frame_start = frame_start_q;
   assign lock_lost   = lock_lost_q;
   assign bad_frames  = bad_frames_q;

endmodule

// File: tb/tb_video_sync_monitor.sv
// Directed bench for video_sync_monitor on a reduced raster (16 clocks x 6 lines);
// all timing relations are the same as for the full 455 x 262 geometry.
module tb_video_sync_monitor;
   localparam int HWD = 5;
   localparam int VWD = 4;
   localparam int HT  = 16;
   localparam int VT  = 6;
   localparam int LF  = 2;
   localparam logic [HWD-1:0] HLEN = HWD'(HT);
   localparam logic [VWD-1:0] VLEN = VWD'(VT);

   logic           clk = 1'b0;
   logic           reset_n = 1'b0;
   logic           hreset_in = 1'b0;
   logic           vreset_in = 1'b0;
   logic [HWD-1:0] hpos, h_len;
   logic [VWD-1:0] vpos, v_len;
   logic           locked, frame_start, lock_lost;
   logic [7:0]     bad_frames;

   int total = 0;
   int bad = 0;
   int fs_cnt = 0, ll_cnt = 0, lock_cyc = 0, unlock_cyc = 0;
   int fs0, ll0, u0, lk0;

   video_sync_monitor #(
      .HW(HWD), .VW(VWD), .H_TOTAL(HT), .V_TOTAL(VT), .LOCK_FRAMES(LF)
   ) dut (
      .clk(clk), ._reset(reset_n), .hreset_in(hreset_in), .vreset_in(vreset_in),
      .hpos(hpos), .vpos(vpos), .h_len(h_len), .v_len(v_len), .locked(locked),
      .frame_start(frame_start), .lock_lost(lock_lost), .bad_frames(bad_frames)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (frame_start) fs_cnt <= fs_cnt + 1;
      if (lock_lost)   ll_cnt <= ll_cnt + 1;
      if (locked)      lock_cyc <= lock_cyc + 1;
      else             unlock_cyc <= unlock_cyc + 1;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic cyc(input logic h, input logic v);
      hreset_in = h;
      vreset_in = v;
      @(posedge clk);
      #1;
   endtask

   task automatic line(input int len, input int hw, input bit vr, input bit vwide);
      for (int i = 0; i < len; i++) cyc(i < hw, vr && (vwide || i < hw));
   endtask

   task automatic frame(input int nl, input int hw, input bit vwide);
      line(HT, hw, 1'b1, vwide);
      for (int l = 1; l < nl; l++) line(HT, hw, 1'b0, 1'b0);
   endtask

   // Completes a nominal frame whose first cycle was already driven.
   task automatic rest_frame();
      for (int i = 1; i < HT; i++) cyc(1'b0, 1'b0);
      for (int l = 1; l < VT; l++) line(HT, 1, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      hreset_in = 1'b0;
      vreset_in = 1'b0;
      reset_n   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      cyc(1'b1, 1'b1);
      cyc(1'b0, 1'b0);
      total++;
      if (hpos !== '0) begin bad++; $display("FAIL rst_hpos: got %0d want 0", hpos); end
      total++;
      if (vpos !== '0) begin bad++; $display("FAIL rst_vpos: got %0d want 0", vpos); end
      total++;
      if (h_len !== '0) begin bad++; $display("FAIL rst_hlen: got %0d want 0", h_len); end
      total++;
      if (v_len !== '0) begin bad++; $display("FAIL rst_vlen: got %0d want 0", v_len); end
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL rst_locked: got %0b want 0", locked); end
      total++;
      if (frame_start !== 1'b0) begin bad++; $display("FAIL rst_fs: got %0b want 0", frame_start); end
      total++;
      if (lock_lost !== 1'b0) begin bad++; $display("FAIL rst_ll: got %0b want 0", lock_lost); end
      total++;
      if (bad_frames !== 8'd0) begin bad++; $display("FAIL rst_bad: got %0d want 0", bad_frames); end
      reset_n = 1'b1;
   endtask

   task automatic test_nominal();
      frame(VT, 1, 1'b0);
      frame(VT, 1, 1'b0);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL nom_prelock: got %0b want 0", locked); end
      cyc(1'b1, 1'b1);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL nom_lock_rise: got %0b want 1", locked); end
      total++;
      if (frame_start !== 1'b1) begin bad++; $display("FAIL nom_fs: got %0b want 1", frame_start); end
      total++;
      if (h_len !== HLEN) begin bad++; $display("FAIL nom_hlen: got %0d want %0d", h_len, HT); end
      total++;
      if (v_len !== VLEN) begin bad++; $display("FAIL nom_vlen: got %0d want %0d", v_len, VT); end
      total++;
      if (vpos !== '0) begin bad++; $display("FAIL nom_vpos0: got %0d want 0", vpos); end
      repeat (HT - 1) cyc(1'b0, 1'b0);
      total++;
      if (hpos !== HWD'(15)) begin bad++; $display("FAIL nom_hpos15: got %0d want 15", hpos); end
      cyc(1'b1, 1'b0);
      total++;
      if (hpos !== '0) begin bad++; $display("FAIL nom_hpos0: got %0d want 0", hpos); end
      total++;
      if (vpos !== VWD'(1)) begin bad++; $display("FAIL nom_vpos1: got %0d want 1", vpos); end
      repeat (HT - 1) cyc(1'b0, 1'b0);
      for (int l = 2; l < VT; l++) line(HT, 1, 1'b0, 1'b0);
      fs0 = fs_cnt;
      u0  = unlock_cyc;
      repeat (10) frame(VT, 1, 1'b0);
      total++;
      if (unlock_cyc - u0 != 0) begin bad++; $display("FAIL nom_stay_locked: got %0d unlocked cycles want 0", unlock_cyc - u0); end
      total++;
      if (fs_cnt - fs0 != 10) begin bad++; $display("FAIL nom_fs_count: got %0d want 10", fs_cnt - fs0); end
      total++;
      if (bad_frames !== 8'd0) begin bad++; $display("FAIL nom_bad: got %0d want 0", bad_frames); end
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL nom_locked_end: got %0b want 1", locked); end
   endtask

   task automatic test_short_line();
      line(HT, 1, 1'b1, 1'b0);
      line(HT, 1, 1'b0, 1'b0);
      line(HT, 1, 1'b0, 1'b0);
      line(HT - 1, 1, 1'b0, 1'b0);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL short_pre: got %0b want 1", locked); end
      ll0 = ll_cnt;
      cyc(1'b1, 1'b0);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL short_drop: got %0b want 0", locked); end
      total++;
      if (lock_lost !== 1'b1) begin bad++; $display("FAIL short_ll: got %0b want 1", lock_lost); end
      total++;
      if (h_len !== HWD'(15)) begin bad++; $display("FAIL short_hlen: got %0d want 15", h_len); end
      cyc(1'b0, 1'b0);
      total++;
      if (lock_lost !== 1'b0) begin bad++; $display("FAIL short_ll_pulse: got %0b want 0", lock_lost); end
      repeat (HT - 2) cyc(1'b0, 1'b0);
      line(HT, 1, 1'b0, 1'b0);
      frame(VT, 1, 1'b0);
      total++;
      if (bad_frames !== 8'd1) begin bad++; $display("FAIL short_bad: got %0d want 1", bad_frames); end
      frame(VT, 1, 1'b0);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL short_prelock: got %0b want 0", locked); end
      cyc(1'b1, 1'b1);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL short_relock: got %0b want 1", locked); end
      total++;
      if (ll_cnt - ll0 != 1) begin bad++; $display("FAIL short_ll_count: got %0d want 1", ll_cnt - ll0); end
      total++;
      if (bad_frames !== 8'd1) begin bad++; $display("FAIL short_bad_end: got %0d want 1", bad_frames); end
      rest_frame();
   endtask

   task automatic test_hreset_stuck();
      cyc(1'b1, 1'b1);
      ll0 = ll_cnt;
      repeat (31) cyc(1'b0, 1'b0);
      total++;
      if (hpos !== HWD'(31)) begin bad++; $display("FAIL stuck_hpos_max: got %0d want 31", hpos); end
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL stuck_pre: got %0b want 1", locked); end
      cyc(1'b0, 1'b0);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL stuck_drop: got %0b want 0", locked); end
      total++;
      if (lock_lost !== 1'b1) begin bad++; $display("FAIL stuck_ll: got %0b want 1", lock_lost); end
      repeat (20) cyc(1'b0, 1'b0);
      total++;
      if (hpos !== HWD'(31)) begin bad++; $display("FAIL stuck_hold: got %0d want 31", hpos); end
      total++;
      if (ll_cnt - ll0 != 1) begin bad++; $display("FAIL stuck_ll_count: got %0d want 1", ll_cnt - ll0); end
      frame(VT, 1, 1'b0);
      frame(VT, 1, 1'b0);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL stuck_prelock: got %0b want 0", locked); end
      cyc(1'b1, 1'b1);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL stuck_relock: got %0b want 1", locked); end
      rest_frame();
   endtask

   task automatic test_wrong_frame_len();
      do_reset();
      lk0 = lock_cyc;
      for (int f = 1; f <= 258; f++) begin
         cyc(1'b1, 1'b1);
         if (f == 2) begin
            total++;
            if (bad_frames !== 8'd1) begin bad++; $display("FAIL wrong_bad1: got %0d want 1", bad_frames); end
            total++;
            if (v_len !== VWD'(7)) begin bad++; $display("FAIL wrong_vlen: got %0d want 7", v_len); end
         end
         if (f == 3) begin
            total++;
            if (bad_frames !== 8'd2) begin bad++; $display("FAIL wrong_bad2: got %0d want 2", bad_frames); end
         end
         if (f == 256) begin
            total++;
            if (bad_frames !== 8'd255) begin bad++; $display("FAIL wrong_bad255: got %0d want 255", bad_frames); end
         end
         repeat (HT - 1) cyc(1'b0, 1'b0);
         for (int l = 1; l < VT + 1; l++) line(HT, 1, 1'b0, 1'b0);
      end
      total++;
      if (bad_frames !== 8'd255) begin bad++; $display("FAIL wrong_sat: got %0d want 255", bad_frames); end
      total++;
      if (lock_cyc - lk0 != 0) begin bad++; $display("FAIL wrong_never_lock: got %0d locked cycles want 0", lock_cyc - lk0); end
   endtask

   task automatic test_wide_pulses();
      do_reset();
      frame(VT, 3, 1'b1);
      frame(VT, 3, 1'b1);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL wide_prelock: got %0b want 0", locked); end
      cyc(1'b1, 1'b1);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL wide_lock_rise: got %0b want 1", locked); end
      total++;
      if (frame_start !== 1'b1) begin bad++; $display("FAIL wide_fs: got %0b want 1", frame_start); end
      total++;
      if (h_len !== HLEN) begin bad++; $display("FAIL wide_hlen: got %0d want %0d", h_len, HT); end
      total++;
      if (v_len !== VLEN) begin bad++; $display("FAIL wide_vlen: got %0d want %0d", v_len, VT); end
      cyc(1'b1, 1'b1);
      total++;
      if (frame_start !== 1'b0) begin bad++; $display("FAIL wide_fs_once: got %0b want 0", frame_start); end
      total++;
      if (hpos !== HWD'(1)) begin bad++; $display("FAIL wide_hpos: got %0d want 1", hpos); end
      cyc(1'b1, 1'b1);
      repeat (HT - 3) cyc(1'b0, 1'b1);
      for (int l = 1; l < VT; l++) line(HT, 3, 1'b0, 1'b0);
      fs0 = fs_cnt;
      u0  = unlock_cyc;
      repeat (10) frame(VT, 3, 1'b1);
      total++;
      if (unlock_cyc - u0 != 0) begin bad++; $display("FAIL wide_stay_locked: got %0d unlocked cycles want 0", unlock_cyc - u0); end
      total++;
      if (fs_cnt - fs0 != 10) begin bad++; $display("FAIL wide_fs_count: got %0d want 10", fs_cnt - fs0); end
      total++;
      if (bad_frames !== 8'd0) begin bad++; $display("FAIL wide_bad: got %0d want 0", bad_frames); end
      total++;
      if (h_len !== HLEN) begin bad++; $display("FAIL wide_hlen_end: got %0d want %0d", h_len, HT); end
   endtask

   task automatic test_reset_mid_frame();
      line(HT, 1, 1'b1, 1'b0);
      line(HT, 1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      repeat (5) cyc(1'b0, 1'b0);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL mid_pre_locked: got %0b want 1", locked); end
      total++;
      if (hpos !== HWD'(5)) begin bad++; $display("FAIL mid_pre_hpos: got %0d want 5", hpos); end
      #2 reset_n = 1'b0;
      #1;
      total++;
      if (hpos !== '0) begin bad++; $display("FAIL mid_hpos: got %0d want 0", hpos); end
      total++;
      if (vpos !== '0) begin bad++; $display("FAIL mid_vpos: got %0d want 0", vpos); end
      total++;
      if (h_len !== '0) begin bad++; $display("FAIL mid_hlen: got %0d want 0", h_len); end
      total++;
      if (v_len !== '0) begin bad++; $display("FAIL mid_vlen: got %0d want 0", v_len); end
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL mid_locked: got %0b want 0", locked); end
      total++;
      if (frame_start !== 1'b0 || lock_lost !== 1'b0) begin bad++; $display("FAIL mid_pulses: got fs=%0b ll=%0b want 0 0", frame_start, lock_lost); end
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      repeat (7) cyc(1'b0, 1'b0);
      cyc(1'b1, 1'b0);
      total++;
      if (h_len !== HWD'(8)) begin bad++; $display("FAIL mid_first_hlen: got %0d want 8", h_len); end
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL mid_unlocked: got %0b want 0", locked); end
      repeat (HT - 1) cyc(1'b0, 1'b0);
      line(HT, 1, 1'b0, 1'b0);
      frame(VT, 1, 1'b0);
      frame(VT, 1, 1'b0);
      total++;
      if (locked !== 1'b0) begin bad++; $display("FAIL mid_prelock: got %0b want 0", locked); end
      cyc(1'b1, 1'b1);
      total++;
      if (locked !== 1'b1) begin bad++; $display("FAIL mid_relock: got %0b want 1", locked); end
      total++;
      if (bad_frames !== 8'd0) begin bad++; $display("FAIL mid_bad: got %0d want 0", bad_frames); end
      total++;
      if (v_len !== VLEN) begin bad++; $display("FAIL mid_vlen_end: got %0d want %0d", v_len, VT); end
      rest_frame();
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_short_line();
      test_hreset_stuck();
      test_wrong_frame_len();
      test_wide_pulses();
      test_reset_mid_frame();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/video_sync_monitor.md
Name: video_sync_monitor

Overview:
- Receiver-side counterpart to the horizontal/vertical timing generators: consumes the hreset/vreset pulse trains and rebuilds the pixel and line position.
- Measures line length (clocks) and frame length (lines), and checks them against the nominal Pong raster (455 clocks × 262 lines).
- Runs a lock state machine whose outputs gate downstream consumers (scan converter, OSD overlay, debug taps).
- Sits beside the video output path, on the pixel clock.

Parameters:
- HW, 10, width of horizontal position/length registers
- VW, 9, width of vertical position/length registers
- H_TOTAL, 455, expected clocks per line
- V_TOTAL, 262, expected lines per frame
- LOCK_FRAMES, 2, consecutive good frames required to assert locked (range 1..15)

Ports:
- clk  in  1  pixel clock; all logic on rising edge
- _reset  in  1  asynchronous active-low reset
- hreset_in  in  1  horizontal reset pulse, active high, synchronous to clk
- vreset_in  in  1  vertical reset pulse, active high, synchronous to clk
- hpos  out  HW  clocks since last line start
- vpos  out  VW  lines since last frame start
- h_len  out  HW  last measured line length
- v_len  out  VW  last measured frame length
- locked  out  1  raster stable and nominal
- frame_start  out  1  one-cycle pulse per detected frame edge
- lock_lost  out  1  one-cycle pulse on LOCKED exit
- bad_frames  out  8  saturating count of rejected frames

Behaviour:
- Reset (_reset low, async):
  - all outputs 0
  - internal prev-input registers 0, h_armed 0, good_cnt 0
  - state ACQUIRE
- Edge detect:
  - hr_edge = hreset_in & ~hreset_q
  - vr_edge = vreset_in & ~vreset_q
  - hreset_q/vreset_q are registered copies of the inputs.
  - A level held high produces exactly one edge.
- Horizontal:
  - On hr_edge: h_len <= hpos+1; hpos <= 0; h_armed <= 1.
  - Otherwise hpos increments.
  - If hpos reaches all-ones, it holds (saturates) and a timeout is raised.
- Line check:
  - line_bad = hr_edge & h_armed & (hpos+1 != H_TOTAL).
  - Unarmed edges (the first edge after reset or timeout) are never checked.
- Vertical:
  - On vr_edge: v_len <= vpos+1; vpos <= 0; frame_start pulses the next cycle.
  - Otherwise, on hr_edge, vpos increments, saturating at all-ones.
  - A vr_edge coinciding with an hr_edge is the normal case: the vertical clear wins and the horizontal actions still occur.
- frame_bad:
  - Latched flag, set by any line_bad during the frame, cleared on vr_edge.
  - A frame is good when vpos+1 == V_TOTAL at its vr_edge and neither frame_bad nor a same-cycle line_bad is set.
- FSM states: ACQUIRE, MEASURE, LOCKED.
  - ACQUIRE: on the first vr_edge, go to MEASURE with good_cnt=0. The partial first frame is not judged.
  - MEASURE, vr_edge with good frame: good_cnt++. When good_cnt+1 == LOCK_FRAMES, go to LOCKED and set locked=1 on the same clock as the transition.
  - MEASURE, vr_edge with bad frame: good_cnt <= 0; bad_frames++.
  - LOCKED, line_bad or bad frame at vr_edge: go to MEASURE immediately with locked=0 and good_cnt=0; pulse lock_lost for one cycle; a bad frame also increments bad_frames.
  - Any state, timeout (hpos or vpos saturated): go to ACQUIRE, h_armed <= 0, locked=0. Pulse lock_lost only if leaving LOCKED.
- Output timing: locked, lock_lost and frame_start are registered, appearing one clock after the qualifying edge cycle.
- bad_frames saturates at 255 and is cleared only by reset.

Test Plan:
1. Nominal raster: hreset_in 1-clk pulse every 455 clocks; vreset_in coincident with every 262nd hreset.
   - Required: h_len=455, v_len=262.
   - Required: locked rises one clock after the 3rd vr_edge (1 acquire + 2 good), and stays high for 10 frames.
   - Required: bad_frames=0; frame_start pulses once per frame.
2. Short line while locked: one line of 454 clocks.
   - Required: locked drops one clock after that hr_edge; lock_lost is a single pulse.
   - Required: relock after 2 further good frames; bad_frames=1.
3. Wrong frame length: 263 lines per frame from reset.
   - Required: locked never asserts; v_len=263; bad_frames increments per frame, saturating at 255.
4. hreset stuck low after lock.
   - Required: hpos saturates at 1023; state goes to ACQUIRE; locked=0; lock_lost pulses once.
   - Required: on restoring nominal input, locked returns after 3 vr_edges.
5. Wide pulses: hreset_in held high 3 clocks, vreset_in held high for a full line.
   - Required: exactly one edge per pulse is counted; measurements and lock are identical to scenario 1.
6. _reset asserted mid-frame while locked.
   - Required: all outputs read 0 asynchronously.
   - Required: after release, the first hr_edge is unchecked and lock is reacquired per scenario 1.
